// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - shared memory-port request/response types and limits
package croc_pkg;

  localparam int unsigned MemWaitMax = 15;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/core_mem_gnt_ctrl.sv
// rtl/core_mem_gnt_ctrl.sv - grant generator holding off each request for WaitCycles cycles
module core_mem_gnt_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned WaitCycles = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic gnt_o
);

  // Out-of-range settings clamp to the longest delay the 4-bit counter can express.
  localparam logic [3:0] WaitLim = 4'((WaitCycles > MemWaitMax) ? MemWaitMax : WaitCycles);

  logic [3:0] wait_cnt;

  assign gnt_o = req_i & (wait_cnt == WaitLim) & ~rst_i;

  // A withdrawn request restarts the wait from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= 4'd0;
    end else if (!req_i || gnt_o) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// rtl/core_mem_responder.sv - req/gnt/rvalid subordinate fronting a 1-cycle SRAM bank
module core_mem_responder
  import croc_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = 32'h1000_0000,
  parameter int unsigned NumWords   = 512,
  parameter int unsigned WaitCycles = 0,
  localparam int unsigned SramAw    = $clog2(NumWords)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic [7:0]        err_count_o,
  output logic              busy_o
);

  // Bounds kept 33 bits wide so a bank ending at the top of the map cannot wrap.
  localparam logic [32:0] BankLo = {1'b0, BaseAddr};
  localparam logic [32:0] BankHi = BankLo + 33'(NumWords) * 33'd4;

  mem_req_t    req;
  mem_rsp_t    rsp;
  logic        gnt;
  logic        hit;
  logic [31:0] offset;
  logic        rvalid_q;
  logic        err_q;
  logic        we_q;
  logic [7:0]  err_count;
  logic        unused_offset_bits;

  assign req = '{req: req_i, we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};

  core_mem_gnt_ctrl #(
    .WaitCycles(WaitCycles)
  ) u_gnt_ctrl (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req.req),
    .gnt_o(gnt)
  );

  assign offset             = req.addr - BaseAddr;
  assign hit                = ({1'b0, req.addr} >= BankLo) && ({1'b0, req.addr} < BankHi);
  assign unused_offset_bits = ^{offset[31:SramAw+2], offset[1:0]};

  assign sram_req_o   = gnt & hit;
  assign sram_we_o    = req.we;
  assign sram_be_o    = req.be;
  assign sram_addr_o  = offset[SramAw+1:2];
  assign sram_wdata_o = req.wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & ~hit;
      we_q     <= gnt & req.we;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count <= 8'd0;
    end else if (rvalid_q && err_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // Only a successful read returns SRAM data; writes and misses answer with zero.
  assign rsp.gnt    = gnt;
  assign rsp.rvalid = rvalid_q;
  assign rsp.err    = rvalid_q & err_q;
  assign rsp.rdata  = (rvalid_q && !err_q && !we_q) ? sram_rdata_i : 32'h0;

  assign gnt_o       = rsp.gnt;
  assign rvalid_o    = rsp.rvalid;
  assign err_o       = rsp.err;
  assign rdata_o     = rsp.rdata;
  assign err_count_o = err_count;
  assign busy_o      = req_i | rvalid_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// tb/tb_core_mem_responder.sv - scoreboard bench over three responders with 0/3/5 wait cycles
module tb_core_mem_responder;

  localparam logic [31:0] Base = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req        [3];
  logic        gnt        [3];
  logic        we         [3];
  logic [3:0]  be         [3];
  logic [31:0] addr       [3];
  logic [31:0] wdata      [3];
  logic        rvalid     [3];
  logic [31:0] rdata      [3];
  logic        err        [3];
  logic        sram_req   [3];
  logic        sram_we    [3];
  logic [3:0]  sram_be    [3];
  logic [8:0]  sram_addr  [3];
  logic [31:0] sram_wdata [3];
  logic [31:0] sram_rdata [3];
  logic [7:0]  err_count  [3];
  logic        busy       [3];

  logic [31:0] shadow [3][512];
  exp_t        sbq[$];
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : {16'hC0DE, 16'(i * 7 + 3)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [31:0] mem [512];

    core_mem_responder #(
      .BaseAddr(32'h1000_0000),
      .NumWords(512),
      .WaitCycles((g == 0) ? 0 : (g == 1) ? 3 : 5)
    ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req[g]), .gnt_o(gnt[g]),
      .we_i(we[g]), .be_i(be[g]), .addr_i(addr[g]), .wdata_i(wdata[g]),
      .rvalid_o(rvalid[g]), .rdata_o(rdata[g]), .err_o(err[g]),
      .sram_req_o(sram_req[g]), .sram_we_o(sram_we[g]), .sram_be_o(sram_be[g]),
      .sram_addr_o(sram_addr[g]), .sram_wdata_o(sram_wdata[g]),
      .sram_rdata_i(sram_rdata[g]), .err_count_o(err_count[g]), .busy_o(busy[g])
    );

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = init_word(i);
      sram_rdata[g] = 32'h0;
    end

    // Single-port SRAM: data of the addressed word appears the cycle after any access.
    always @(posedge clk) begin
      if (sram_req[g]) begin
        sram_rdata[g] <= mem[sram_addr[g]];
        if (sram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (i != sel || sbq.size() == 0) begin
          check_eq("spurious_rvalid", 32'(i), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_eq("rsp_rdata", rdata[i], e.rdata);
          check_eq("rsp_err", 32'(err[i]), 32'(e.err));
        end
      end
    end
  end

  // Called at a negedge; holds the request until granted and returns at the next negedge.
  task automatic do_req(input int idx, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input int exp_wait);
    logic        hit;
    logic [8:0]  word;
    exp_t        e;
    int          n;
    hit  = (a >= Base) && (a < Base + 32'h800);
    word = 9'((a - Base) >> 2);
    req[idx] = 1'b1; we[idx] = w; be[idx] = b; addr[idx] = a; wdata[idx] = d;
    n = 0;
    #1;
    while (gnt[idx] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      #1;
    end
    if (gnt[idx] !== 1'b1) begin
      check_eq("gnt_timeout", 32'(n), 32'(exp_wait));
      req[idx] = 1'b0;
      return;
    end
    check_eq("gnt_wait", 32'(n), 32'(exp_wait));
    check_eq("sram_req", 32'(sram_req[idx]), 32'(hit));
    check_eq("busy_req", 32'(busy[idx]), 32'd1);
    if (hit) begin
      check_eq("sram_addr", 32'(sram_addr[idx]), 32'(word));
      check_eq("sram_we", 32'(sram_we[idx]), 32'(w));
      check_eq("sram_be", 32'(sram_be[idx]), 32'(b));
      check_eq("sram_wdata", sram_wdata[idx], d);
    end
    e.err   = ~hit;
    e.rdata = (hit && !w) ? shadow[idx][word] : 32'h0;
    sbq.push_back(e);
    if (hit && w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) shadow[idx][word][8*k +: 8] = d[8*k +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int idx, input int cycles);
    req[idx] = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_quiet(input int idx, input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt[idx]), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(rvalid[idx]), 32'd0);
    check_eq({tag, "_err"}, 32'(err[idx]), 32'd0);
    check_eq({tag, "_rdata"}, rdata[idx], 32'h0);
    check_eq({tag, "_sram_req"}, 32'(sram_req[idx]), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count[idx]), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
      for (int j = 0; j < 512; j++) shadow[i][j] = init_word(j);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_quiet(i, "reset");
    rst = 1'b0;
    @(negedge clk);

    sel = 0;
    do_req(0, 1'b0, 4'hF, 32'h1000_0010, 32'h0, 0);
    idle(0, 2);

    sel = 1;
    do_req(1, 1'b1, 4'b0011, 32'h1000_0000, 32'h1234_5678, 3);
    idle(1, 1);
    do_req(1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 3);
    idle(1, 2);

    sel = 0;
    for (int i = 0; i < 4; i++) do_req(0, 1'b0, 4'hF, Base + 32'(4 * i), 32'h0, 0);
    do_req(0, 1'b0, 4'hF, 32'h1000_07FC, 32'h0, 0);
    idle(0, 2);

    do_req(0, 1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0, 0);
    do_req(0, 1'b1, 4'hF, 32'h1000_0800, 32'hFFFF_FFFF, 0);
    idle(0, 1);
    check_eq("err_count_2", 32'(err_count[0]), 32'd2);
    for (int i = 0; i < 253; i++) do_req(0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0, 0);
    idle(0, 1);
    check_eq("err_count_255", 32'(err_count[0]), 32'hFF);
    for (int i = 0; i < 47; i++) do_req(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 0);
    idle(0, 1);
    check_eq("err_count_sat", 32'(err_count[0]), 32'hFF);
    idle(0, 1);

    sel = 2;
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h1000_0020;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("drop_gnt", 32'(gnt[2]), 32'd0);
      check_eq("drop_busy", 32'(busy[2]), 32'd1);
      @(negedge clk);
    end
    idle(2, 3);
    do_req(2, 1'b0, 4'hF, 32'h1000_0020, 32'h0, 5);
    idle(2, 2);

    sel = 0;
    do_req(0, 1'b0, 4'hF, 32'h1000_0004, 32'h0, 0);
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check_quiet(0, "mid_reset");
    req[0] = 1'b1; addr[0] = 32'h1000_0008;
    #1;
    check_eq("rst_gnt_forced", 32'(gnt[0]), 32'd0);
    check_eq("rst_sram_req_forced", 32'(sram_req[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b0;
    do_req(0, 1'b0, 4'hF, 32'h1000_0008, 32'h0, 0);
    idle(0, 2);

    sel = 1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1000_0010;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 1'b0, 4'hF, 32'h1000_0010, 32'h0, 3);
    idle(1, 3);

    check_eq("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Subordinate (memory-side) end of the core's req/gnt/rvalid instruction/data memory protocol.
- Accepts core requests and grants them after a configurable number of wait cycles.
- Drives a single-port, 1-cycle-latency SRAM macro and returns rvalid/rdata/err one cycle after each grant.
- Instantiated once per core port (instr or data) in front of a local SRAM bank.

Parameters:
- BaseAddr, 32'h1000_0000, byte base address of the bank.
- NumWords, 512, bank depth in 32-bit words (power of two, ≥2).
- WaitCycles, 0, grant delay in cycles, range 0..15.
- SramAw, $clog2(NumWords), derived SRAM word-address width (localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  request, held until gnt_o
- gnt_o  out  1  request granted this cycle
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid (exactly one per grant)
- rdata_o  out  32  read data
- err_o  out  1  response error (qualified by rvalid_o)
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  4  SRAM byte enables
- sram_addr_o  out  SramAw  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid the cycle after sram_req_o
- err_count_o  out  8  saturating count of error responses
- busy_o  out  1  request pending or response in flight

Behaviour:
- Reset (rst_i=1 at posedge): wait_cnt=0, rvalid_q=0, err_q=0, we_q=0, err_count=0.
- While rst_i=1, gnt_o and sram_req_o are forced 0 combinationally.
- Outputs after reset: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, sram_req_o=0, err_count_o=0, busy_o=0.
- Wait counter wait_cnt (4 bit):
  - gnt_o = req_i & (wait_cnt == WaitCycles) & ~rst_i.
  - With WaitCycles=0, gnt_o is combinational from req_i, so the same cycle grants.
  - Increment when req_i & ~gnt_o.
  - Clear to 0 on gnt_o, or when req_i=0 (request withdrawn before grant: no access, no response).
- Address decode (combinational):
  - hit = (addr_i ≥ BaseAddr) & (addr_i < BaseAddr + 4*NumWords), compared on 33-bit unsigned values so the upper bound cannot wrap.
  - addr_i[1:0] is ignored.
  - sram_addr_o = (addr_i − BaseAddr)[SramAw+1:2].
- Grant cycle N:
  - sram_req_o = gnt_o & hit.
  - sram_we_o/sram_be_o/sram_wdata_o pass through we_i/be_i/wdata_i.
  - Register rvalid_q=1, err_q=~hit, we_q=we_i.
- Response cycle N+1:
  - rvalid_o = rvalid_q, err_o = rvalid_q & err_q.
  - rdata_o = sram_rdata_i when rvalid_q & ~err_q & ~we_q; otherwise 32'h0.
  - A miss write is discarded with no SRAM access.
- Pipelining: a new grant is allowed in the same cycle as a response. Steady-state throughput is 1 transaction per cycle at WaitCycles=0, and 1 per (WaitCycles+1) cycles otherwise. There is no response backpressure.
- When there is no grant in cycle N, rvalid_q=0 at N+1.
- err_count: increments on each error response (rvalid_q & err_q) and saturates at 8'hFF.
- busy_o = req_i | rvalid_q.
- Reset mid-operation: a pending response is dropped (rvalid_o=0 the cycle after reset is asserted) and wait_cnt restarts at 0.

Decomposition:
- croc_pkg holds:
  - the mem_req_t struct {req, we, be, addr, wdata};
  - the mem_rsp_t struct {gnt, rvalid, rdata, err};
  - the MemWaitMax=15 constant.
- The grant/wait counter is a natural sub-module, core_mem_gnt_ctrl, with ports clk_i, rst_i, req_i, gnt_o.
- Decode, response register and error counter stay in the top level.

Test Plan:
- WaitCycles=0; read 0x1000_0010 with the SRAM model word 4 = 0xDEADBEEF → gnt_o same cycle; sram_addr_o=4; next cycle rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0.
- WaitCycles=3; write 0x1000_0000, be=4'b0011, wdata=0x1234_5678 → gnt_o on the 4th cycle of req_i; sram_req_o/sram_we_o=1 in that cycle with be 0011; rvalid_o next cycle with rdata_o=0.
- WaitCycles=0; 4 back-to-back reads of words 0..3 → gnt_o every cycle; rvalid_o high 4 consecutive cycles; data returned in order.
- Read 0x0FFF_FFFC and write 0x1000_0800 (NumWords=512) → no sram_req_o; err_o=1 with rdata_o=0; err_count_o=2. Then force 300 errors → err_count_o=0xFF.
- WaitCycles=5; req_i dropped after 2 cycles, then re-raised → no grant or response for the dropped request; new grant after 6 cycles of req_i.
- rst_i asserted in the cycle after a grant → rvalid_o=0 the next cycle; all outputs at reset values; a request after reset completes normally.
